// File: rtl/axils_regs_pkg.sv
// Shared response codes, write-FSM states and the byte-strobe merge helper
// used by the AXI4-Lite register block.
package axils_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axils_wr_ch.sv
// AXI4-Lite write path: independent AW/W holding registers, commit of the
// write into the register file, and the B response channel.
module axils_wr_ch
    import axils_regs_pkg::*;
#(
    parameter int unsigned NREGS     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [31:0]           AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    output logic [NREGS*32-1:0]   reg_q,
    output logic [NREGS-1:0]      reg_wr
);

    wr_state_e          state_q;
    logic               aw_held_q;
    logic               w_held_q;
    logic [29:0]        aw_idx_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;
    logic [1:0]         bresp_q;
    logic [NREGS-1:0]   reg_wr_q;
    logic [31:0]        regs_q [NREGS];

    logic               aw_hs;
    logic               w_hs;
    logic               commit_d;
    logic               in_range_d;
    logic [29:0]        wr_idx_d;
    logic [31:0]        wr_data_d;
    logic [3:0]         wr_strb_d;

    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^AWADDR[1:0];

    assign AWREADY = !aw_held_q && (state_q == W_IDLE);
    assign WREADY  = !w_held_q && (state_q == W_IDLE);
    assign BVALID  = (state_q == W_RESP);
    assign BRESP   = bresp_q;
    assign reg_wr  = reg_wr_q;

    // Pick held or live AW/W values; a write commits once both halves exist
    always_comb begin
        aw_hs      = AWVALID && AWREADY;
        w_hs       = WVALID && WREADY;
        wr_idx_d   = aw_held_q ? aw_idx_q : AWADDR[31:2];
        wr_data_d  = w_held_q ? w_data_q : WDATA;
        wr_strb_d  = w_held_q ? w_strb_q : WSTRB;
        commit_d   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        in_range_d = (wr_idx_d < 30'(NREGS));
    end

    // Write FSM, holding registers and register storage
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            reg_wr_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            reg_wr_q <= '0;
            case (state_q)
                W_IDLE: begin
                    if (commit_d) begin
                        state_q   <= W_RESP;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        bresp_q   <= in_range_d ? RESP_OKAY : RESP_SLVERR;
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            if (in_range_d && (wr_idx_d == 30'(i))) begin
                                regs_q[i]   <= apply_wstrb(regs_q[i], wr_data_d, wr_strb_d);
                                reg_wr_q[i] <= 1'b1;
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_idx_q  <= AWADDR[31:2];
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        state_q <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    // Flatten the register file onto the reg_q bus
    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            reg_q[32*i +: 32] = regs_q[i];
        end
    end

endmodule

// File: rtl/axils_regs.sv
// AXI4-Lite slave exposing NREGS 32-bit registers. Write path lives in
// axils_wr_ch; the single-beat read path is handled here.
module axils_regs
    import axils_regs_pkg::*;
#(
    parameter int unsigned NREGS     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [31:0]           AWADDR,
    input  logic [2:0]            AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    input  logic [31:0]           ARADDR,
    input  logic [2:0]            ARPROT,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [NREGS*32-1:0]   reg_q,
    output logic [NREGS-1:0]      reg_wr
);

    logic [NREGS*32-1:0] regs_flat;
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic [31:0]         rd_data_d;
    logic [1:0]          rd_resp_d;
    logic [29:0]         ar_idx;

    logic                unused_inputs;
    assign unused_inputs = ^{AWPROT, ARPROT, ARADDR[1:0]};

    axils_wr_ch #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_wr_ch (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .reg_q   (regs_flat),
        .reg_wr  (reg_wr)
    );

    assign reg_q   = regs_flat;
    assign ar_idx  = ARADDR[31:2];
    assign ARREADY = !rvalid_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    // Decode the read address against current (pre-write) register contents
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_SLVERR;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (ar_idx == 30'(i)) begin
                rd_data_d = regs_flat[32*i +: 32];
                rd_resp_d = RESP_OKAY;
            end
        end
    end

    // Read response register: load on AR handshake, hold until RREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ARVALID && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axils_regs.sv
// Self-checking bench for axils_regs: directed scenarios followed by random
// reads/writes compared against a transaction-level register model.
module tb_axils_regs;

    localparam int NREGS = 8;
    localparam logic [31:0] RVAL = 32'h0000_0000;

    logic                ACLK = 1'b0;
    logic                ARESET;
    logic [31:0]         AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [31:0]         WDATA;
    logic [3:0]          WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic                BVALID;
    logic                BREADY;
    logic [1:0]          BRESP;
    logic [31:0]         ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;
    logic [NREGS*32-1:0] reg_q;
    logic [NREGS-1:0]    reg_wr;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NREGS];

    axils_regs #(
        .NREGS     (NREGS),
        .RESET_VAL (RVAL)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .reg_q   (reg_q),
        .reg_wr  (reg_wr)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], model[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = RVAL;
    endtask

    // Full write transaction with independent AW / W start delays
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int aw_dly, input int w_dly);
        int          cyc;
        bit          aw_done, w_done, aw_fire, w_fire;
        logic [29:0] idx;
        logic [31:0] exp_wr;
        cyc = 0; aw_done = 0; w_done = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        AWVALID = 0; WVALID = 0;
        chk("wr_handshake", {31'b0, aw_done && w_done}, 32'd1);
        idx = addr[31:2];
        exp_wr = 32'd0;
        if (idx < NREGS) begin
            exp_wr = 32'd1 << idx;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        chk("wr_bvalid", {31'b0, BVALID}, 32'd1);
        chk("wr_bresp", {30'b0, BRESP}, (idx < NREGS) ? 32'd0 : 32'd2);
        chk("wr_regwr", {24'b0, reg_wr}, exp_wr);
        chk_regs("wr");
        BREADY = 1;
        tick();
        BREADY = 0;
        chk("wr_bclear", {31'b0, BVALID}, 32'd0);
        chk("wr_regwr_end", {24'b0, reg_wr}, 32'd0);
    endtask

    // Full read transaction; RREADY withheld for rr_dly cycles
    task automatic rd(input logic [31:0] addr, input int rr_dly);
        int          cyc;
        bit          done, fire;
        logic [29:0] idx;
        logic [31:0] exp_d;
        logic [31:0] exp_r;
        idx = addr[31:2];
        exp_d = 32'd0; exp_r = 32'd2;
        if (idx < NREGS) begin exp_d = model[idx]; exp_r = 32'd0; end
        ARADDR = addr; ARVALID = 1;
        cyc = 0; done = 0;
        while (!done && cyc < 20) begin
            fire = ARREADY;
            tick();
            if (fire) done = 1;
            cyc++;
        end
        ARVALID = 0;
        chk("rd_handshake", {31'b0, done}, 32'd1);
        chk("rd_rvalid", {31'b0, RVALID}, 32'd1);
        chk("rd_rdata", RDATA, exp_d);
        chk("rd_rresp", {30'b0, RRESP}, exp_r);
        for (int k = 0; k < rr_dly; k++) begin
            tick();
            chk("rd_hold_rvalid", {31'b0, RVALID}, 32'd1);
            chk("rd_hold_rdata", RDATA, exp_d);
            chk("rd_hold_arready", {31'b0, ARREADY}, 32'd0);
        end
        RREADY = 1;
        tick();
        RREADY = 0;
        chk("rd_rclear", {31'b0, RVALID}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] bresp_snap;
        ARESET = 1; AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0;
        WVALID = 0; BREADY = 0; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 0;

        // Reset state
        chk("rst_awready", {31'b0, AWREADY}, 32'd1);
        chk("rst_wready", {31'b0, WREADY}, 32'd1);
        chk("rst_arready", {31'b0, ARREADY}, 32'd1);
        chk("rst_bvalid", {31'b0, BVALID}, 32'd0);
        chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_regwr", {24'b0, reg_wr}, 32'd0);
        chk_regs("rst");

        // Simultaneous AW+W, BREADY already high
        BREADY = 1;
        AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0;
        chk("sim_bvalid", {31'b0, BVALID}, 32'd1);
        chk("sim_bresp", {30'b0, BRESP}, 32'd0);
        chk("sim_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("sim_regwr", {24'b0, reg_wr}, 32'h2);
        tick();
        BREADY = 0;
        chk("sim_bclear", {31'b0, BVALID}, 32'd0);
        chk("sim_regwr_once", {24'b0, reg_wr}, 32'd0);
        model[1] = 32'hDEADBEEF;

        // W leads AW by three cycles, partial strobe
        wr(32'h08, 32'hAAAAAAAA, 4'hF, 0, 0);
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1;
        tick();
        WVALID = 0;
        for (int k = 0; k < 3; k++) begin
            chk("wfirst_wready", {31'b0, WREADY}, 32'd0);
            chk("wfirst_awready", {31'b0, AWREADY}, 32'd1);
            chk("wfirst_bvalid", {31'b0, BVALID}, 32'd0);
            if (k < 2) tick();
        end
        AWADDR = 32'h08; AWVALID = 1;
        tick();
        AWVALID = 0;
        chk("wfirst_bvalid1", {31'b0, BVALID}, 32'd1);
        chk("wfirst_reg2", reg_q[95:64], 32'hAA22AA44);
        chk("wfirst_regwr", {24'b0, reg_wr}, 32'h4);
        model[2] = 32'hAA22AA44;
        BREADY = 1; tick(); BREADY = 0;

        // Out-of-range read and write
        rd(32'h20, 0);
        wr(32'h20, 32'hCAFEF00D, 4'hF, 0, 0);

        // Back-pressure on B for 5 cycles; a second AW must wait
        AWADDR = 32'h0C; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        tick();
        WVALID = 0;
        AWADDR = 32'h10;
        model[3] = 32'h12345678;
        chk("bp_bvalid0", {31'b0, BVALID}, 32'd1);
        bresp_snap = {30'b0, BRESP};
        chk("bp_bresp0", bresp_snap, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid", {31'b0, BVALID}, 32'd1);
            chk("bp_bresp", {30'b0, BRESP}, 32'd0);
            chk("bp_awready", {31'b0, AWREADY}, 32'd0);
            chk("bp_wready", {31'b0, WREADY}, 32'd0);
            tick();
        end
        BREADY = 1;
        tick();
        BREADY = 0;
        chk("bp_bclear", {31'b0, BVALID}, 32'd0);
        chk("bp_awready_after", {31'b0, AWREADY}, 32'd1);
        tick();
        AWVALID = 0;
        chk("bp_aw_held", {31'b0, AWREADY}, 32'd0);
        chk("bp_no_commit", {31'b0, BVALID}, 32'd0);
        WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1;
        tick();
        WVALID = 0;
        model[4] = 32'h0BADF00D;
        chk("bp2_bvalid", {31'b0, BVALID}, 32'd1);
        chk_regs("bp2");
        BREADY = 1; tick(); BREADY = 0;

        // Read on the same edge as a write commit returns the old value
        wr(32'h04, 32'h0, 4'hF, 0, 0);
        AWADDR = 32'h04; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = 32'h04;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("rw_rvalid", {31'b0, RVALID}, 32'd1);
        chk("rw_rdata_old", RDATA, 32'h0);
        chk("rw_bvalid", {31'b0, BVALID}, 32'd1);
        chk("rw_reg1", reg_q[63:32], 32'h5);
        model[1] = 32'h5;
        BREADY = 1; RREADY = 1; tick(); BREADY = 0; RREADY = 0;
        rd(32'h04, 1);

        // Reset with AW held and a read response pending
        AWADDR = 32'h14; AWVALID = 1;
        tick();
        AWVALID = 0;
        ARADDR = 32'h0; ARVALID = 1;
        tick();
        ARVALID = 0;
        chk("mrst_rvalid_pre", {31'b0, RVALID}, 32'd1);
        ARESET = 1;
        tick();
        ARESET = 0;
        model_reset();
        chk("mrst_rvalid", {31'b0, RVALID}, 32'd0);
        chk("mrst_rdata", RDATA, 32'd0);
        chk("mrst_awready", {31'b0, AWREADY}, 32'd1);
        chk("mrst_wready", {31'b0, WREADY}, 32'd1);
        chk("mrst_arready", {31'b0, ARREADY}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("mrst_bvalid", {31'b0, BVALID}, 32'd0);
            tick();
        end
        chk_regs("mrst");

        // Random traffic against the register model
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, NREGS + 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                wr(a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd(a, $urandom_range(0, 2));
        end
        chk_regs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axils_regs.md
AXILS_REGS -- requirements
Module: axils_regs

Parameters
REQ-001 The block SHALL have parameter NREGS, default 8, giving the number of 32-bit registers (2..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 32'h0000_0000, giving the reset value of every register.

Interface
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  synchronous reset, active-high.
REQ-005 AWADDR  in  32  write address; AWPROT  in  3  ignored; AWVALID  in  1; AWREADY  out  1.
REQ-006 WDATA  in  32; WSTRB  in  4  byte enables; WVALID  in  1; WREADY  out  1.
REQ-007 BVALID  out  1; BREADY  in  1; BRESP  out  2  write response.
REQ-008 ARADDR  in  32; ARPROT  in  3  ignored; ARVALID  in  1; ARREADY  out  1.
REQ-009 RDATA  out  32; RRESP  out  2; RVALID  out  1; RREADY  in  1.
REQ-010 reg_q  out  NREGS*32  current register contents; register i occupies bits [32*i+31:32*i].
REQ-011 reg_wr  out  NREGS  one-cycle pulse per register on the cycle after it is written.

Function
REQ-012 Register index = ADDR[31:2]; ADDR[1:0] SHALL be ignored; index >= NREGS is out of range.
REQ-013 AWREADY SHALL equal (no AW held) AND (BVALID==0); WREADY SHALL equal (no W held) AND (BVALID==0).
REQ-014 AW and W SHALL be accepted independently, in either order or in the same cycle, each into a holding register.
REQ-015 On the edge where both AW and W are available (held, or handshaking that cycle), the write SHALL commit: bytes with WSTRB[b]=1 updated, others kept; BVALID set; both holds cleared.
REQ-016 In-range write: BRESP=2'b00 (OKAY); out-of-range write: no register changes, BRESP=2'b10 (SLVERR).
REQ-017 WSTRB=4'b0000 in range SHALL leave the register unchanged, return OKAY, and still pulse reg_wr.
REQ-018 BVALID and BRESP SHALL hold stable until BREADY=1 at a rising edge; BVALID clears on that edge.
REQ-019 Write FSM states: W_IDLE (accepting AW/W) -> W_RESP (BVALID=1) -> W_IDLE on BREADY; minimum latency from simultaneous AW+W handshake to BVALID = 1 cycle.
REQ-020 ARREADY SHALL equal NOT RVALID.
REQ-021 On AR handshake, the next edge SHALL load RDATA = addressed register (in range, RRESP=2'b00) or 32'h0 (out of range, RRESP=2'b10), and set RVALID.
REQ-022 RVALID, RDATA, RRESP SHALL hold stable until RREADY=1 at a rising edge; RVALID clears on that edge.
REQ-023 Read and write channels SHALL operate concurrently; a read handshaking on the same edge a write commits to the same register SHALL return the pre-write value.
REQ-024 VALID outputs SHALL never depend combinationally on READY inputs; all outputs SHALL be registered.

Reset
REQ-025 While ARESET=1 at an edge: every register = RESET_VAL, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, reg_wr=0, holds cleared, FSM = W_IDLE.
REQ-026 Reset mid-transaction SHALL abandon it with no register update and no response issued afterwards.
REQ-027 AWREADY, WREADY, ARREADY SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the response constants (OKAY=2'b00, SLVERR=2'b10) and the write-FSM state enum.
REQ-029 The block SHALL be split into sub-module axils_wr_ch (AW/W/B channels, register storage) and read logic; read logic SHALL be inline in axils_regs.

Verification
REQ-030 Simultaneous AW=0x04, W=0xDEADBEEF, WSTRB=4'hF, BREADY=1 -> BVALID one cycle later, BRESP=00, reg 1=0xDEADBEEF, reg_wr[1] pulses once.
REQ-031 W (0x11223344, WSTRB=4'b0101) three cycles before AW=0x08 on a reg holding 0xAAAAAAAA -> WREADY low after W accepted, reg 2=0xAA22AA44.
REQ-032 AR=0x20 with NREGS=8 -> RDATA=0, RRESP=10; AW=0x20 write -> BRESP=10, reg_q unchanged.
REQ-033 BREADY=0 for 5 cycles after write commit -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, second AW accepted only after B handshake.
REQ-034 AR=0x04 handshake on same edge as write commit of 0x5 to reg 1 (previously 0x0) -> RDATA=0x0; subsequent read -> 0x5.
REQ-035 ARESET asserted with AW held and RVALID=1 -> next cycle RVALID=0, BVALID never asserts, all regs = RESET_VAL, READYs = 1 after release.
